// File: rtl/keep_one_in_n_unzip.sv
// rtl/keep_one_in_n_unzip.sv - expands each packed 4-byte word into four 32-bit samples
module keep_one_in_n_unzip #(
    parameter int WIDTH     = 32,
    parameter int FILL_MODE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready
);

    logic [WIDTH-1:0] hold_data;
    logic             hold_last;
    logic             full;
    logic [1:0]       idx;
    logic [7:0]       sel_byte;
    logic             last_sub;
    logic             out_hs;
    logic             in_hs;

    assign last_sub = (idx == 2'd3);
    assign out_hs   = full & o_tready;
    assign in_hs    = i_tvalid & i_tready;

    // Refill is allowed while the final sub-sample leaves, so words stream back-to-back.
    assign i_tready = ~full | (o_tready & last_sub);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_data <= '0;
            hold_last <= 1'b0;
            full      <= 1'b0;
            idx       <= 2'd0;
        end else if (in_hs) begin
            hold_data <= i_tdata;
            hold_last <= i_tlast;
            full      <= 1'b1;
            idx       <= 2'd0;
        end else if (out_hs) begin
            if (last_sub) begin
                idx  <= 2'd0;
                full <= 1'b0;
            end else begin
                idx <= idx + 2'd1;
            end
        end
    end

    // The packer stores sample pairs swapped within each half-word.
    always_comb begin
        sel_byte = hold_data[23:16];
        case (idx)
            2'd0: sel_byte = hold_data[23:16];
            2'd1: sel_byte = hold_data[31:24];
            2'd2: sel_byte = hold_data[7:0];
            2'd3: sel_byte = hold_data[15:8];
            default: sel_byte = hold_data[23:16];
        endcase
    end

    generate
        if (FILL_MODE == 1) begin : g_fill_rep
            assign o_tdata = {sel_byte, sel_byte, {(WIDTH-16){1'b0}}};
        end else begin : g_fill_zero
            assign o_tdata = {sel_byte, {(WIDTH-8){1'b0}}};
        end
    endgenerate

    assign o_tvalid = full;
    assign o_tlast  = full & hold_last & last_sub;

endmodule

// File: tb/tb_keep_one_in_n_unzip.sv
// tb/tb_keep_one_in_n_unzip.sv - self-checking bench for keep_one_in_n_unzip (both fill modes)
module tb_keep_one_in_n_unzip;

    logic        clk;
    logic        reset;
    logic [31:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        o_tready;

    logic        i_tready0, i_tready1;
    logic [31:0] o_tdata0, o_tdata1;
    logic        o_tlast0, o_tlast1;
    logic        o_tvalid0, o_tvalid1;

    keep_one_in_n_unzip #(.WIDTH(32), .FILL_MODE(0)) dut0 (
        .clk(clk), .reset(reset),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready0),
        .o_tdata(o_tdata0), .o_tlast(o_tlast0), .o_tvalid(o_tvalid0), .o_tready(o_tready)
    );

    keep_one_in_n_unzip #(.WIDTH(32), .FILL_MODE(1)) dut1 (
        .clk(clk), .reset(reset),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready1),
        .o_tdata(o_tdata1), .o_tlast(o_tlast1), .o_tvalid(o_tvalid1), .o_tready(o_tready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sample k of a packed word, in restored order, with the requested fill.
    function automatic logic [31:0] expand(input logic [31:0] w, input int fm, input int k);
        logic [7:0] b;
        case (k)
            0: b = w[23:16];
            1: b = w[31:24];
            2: b = w[7:0];
            default: b = w[15:8];
        endcase
        return (fm == 1) ? {b, b, 16'h0} : {b, 24'h0};
    endfunction

    // Inverse of expand: four sample top bytes back into one word.
    function automatic logic [31:0] pack(input logic [7:0] s0, input logic [7:0] s1,
                                         input logic [7:0] s2, input logic [7:0] s3);
        return {s1, s0, s3, s2};
    endfunction

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        last;
    } samp_t;

    samp_t q[$];
    int    cyc     = 0;
    int    acc_cyc = 0;

    // Reference: each accepted word becomes four pending samples; one leaves per ready cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
        end else begin
            bit rdy;
            samp_t s;
            rdy = (q.size() == 0) || (q.size() == 1 && o_tready);
            if (q.size() != 0 && o_tready) void'(q.pop_front());
            if (i_tvalid && rdy) begin
                acc_cyc = cyc;
                for (int k = 0; k < 4; k++) begin
                    s.d0   = expand(i_tdata, 0, k);
                    s.d1   = expand(i_tdata, 1, k);
                    s.last = i_tlast && (k == 3);
                    q.push_back(s);
                end
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            bit exp_rdy;
            exp_rdy = (q.size() == 0) || (q.size() == 1 && o_tready);
            chk("i_tready0", 32'(i_tready0), 32'(exp_rdy));
            chk("i_tready1", 32'(i_tready1), 32'(exp_rdy));
            chk("o_tvalid0", 32'(o_tvalid0), 32'(q.size() != 0));
            chk("o_tvalid1", 32'(o_tvalid1), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("o_tdata0", o_tdata0, q[0].d0);
                chk("o_tdata1", o_tdata1, q[0].d1);
                chk("o_tlast0", 32'(o_tlast0), 32'(q[0].last));
                chk("o_tlast1", 32'(o_tlast1), 32'(q[0].last));
            end else begin
                chk("o_tlast0_idle", 32'(o_tlast0), 32'h0);
            end
        end
    end

    logic [31:0] log0[$];
    logic [31:0] log1[$];
    bit          logl[$];
    int          logc[$];

    always @(negedge clk) begin
        if (!reset && o_tvalid0 && o_tready) begin
            log0.push_back(o_tdata0);
            log1.push_back(o_tdata1);
            logl.push_back(o_tlast0);
            logc.push_back(cyc);
        end
    end

    bit bp_en  = 0;
    int bp_cnt = 0;

    initial begin
        o_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (!bp_en) begin
                o_tready = 1'b1;
                bp_cnt   = 0;
            end else begin
                case (bp_cnt)
                    0, 3:    o_tready = 1'b1;
                    1, 2:    o_tready = 1'b0;
                    default: o_tready = ($urandom_range(0, 3) != 0);
                endcase
                bp_cnt++;
            end
        end
    end

    task automatic clear_log();
        log0.delete();
        log1.delete();
        logl.delete();
        logc.delete();
    endtask

    task automatic send(input logic [31:0] w, input logic l);
        int t;
        bit hs;
        t        = 0;
        hs       = 0;
        i_tvalid = 1'b1;
        i_tdata  = w;
        i_tlast  = l;
        while (!hs && t < 500) begin
            @(negedge clk);
            hs = i_tready0;
            @(posedge clk);
            #1;
            t++;
        end
        if (!hs) chk("send_timeout", 32'(t), 32'h0);
        i_tvalid = 1'b0;
        i_tdata  = 32'hDEADBEEF;
        i_tlast  = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_timeout", 32'(q.size()), 32'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [31:0] words[$];
    logic [7:0]  samp[$];

    initial begin
        int gaps;
        int nl;
        int lpos;
        int t;
        reset    = 1'b1;
        i_tvalid = 1'b0;
        i_tdata  = 32'h0;
        i_tlast  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_o_tvalid", 32'({o_tvalid0, o_tvalid1}), 32'h0);
        chk("rst_o_tlast",  32'({o_tlast0, o_tlast1}), 32'h0);
        chk("rst_o_tdata0", o_tdata0, 32'h0);
        chk("rst_o_tdata1", o_tdata1, 32'h0);
        chk("rst_i_tready", 32'({i_tready0, i_tready1}), 32'h3);

        chk("model_fill1_k0", expand(32'h12345678, 1, 0), 32'h34340000);
        chk("model_fill1_k3", expand(32'h12345678, 1, 3), 32'h56560000);
        chk("model_fill0_k2", expand(32'hAABBCCDD, 0, 2), 32'hDD000000);
        chk("model_pack",     pack(8'hBB, 8'hAA, 8'hDD, 8'hCC), 32'hAABBCCDD);

        @(posedge clk);
        #1;
        clear_log();
        send(32'hAABBCCDD, 1'b1);
        drain();
        chk("single_count", 32'(log0.size()), 32'd4);
        if (log0.size() == 4) begin
            chk("single_b0", log0[0], 32'hBB000000);
            chk("single_b1", log0[1], 32'hAA000000);
            chk("single_b2", log0[2], 32'hDD000000);
            chk("single_b3", log0[3], 32'hCC000000);
            chk("single_last", 32'({logl[0], logl[1], logl[2], logl[3]}), 32'h1);
            chk("single_latency", 32'(logc[0] - acc_cyc), 32'd1);
            chk("single_contig", 32'(logc[3] - logc[0]), 32'd3);
        end

        clear_log();
        for (int w = 0; w < 8; w++)
            send(32'h11223344 + 32'(w) * 32'h01010101, w == 7);
        drain();
        chk("stream_count", 32'(log0.size()), 32'd32);
        gaps = 0;
        nl   = 0;
        lpos = -1;
        for (int i = 0; i < log0.size(); i++) begin
            if (i > 0 && logc[i] != logc[i-1] + 1) gaps++;
            if (logl[i]) begin
                nl++;
                lpos = i;
            end
        end
        chk("stream_gaps",  32'(gaps), 32'h0);
        chk("stream_nlast", 32'(nl), 32'd1);
        chk("stream_lpos",  32'(lpos), 32'd31);

        clear_log();
        send(32'h12345678, 1'b0);
        drain();
        chk("fill1_count", 32'(log1.size()), 32'd4);
        if (log1.size() == 4) begin
            chk("fill1_b0", log1[0], 32'h34340000);
            chk("fill1_b1", log1[1], 32'h12120000);
            chk("fill1_b2", log1[2], 32'h78780000);
            chk("fill1_b3", log1[3], 32'h56560000);
        end

        // Random samples packed 4:1, then restored under backpressure.
        clear_log();
        samp.delete();
        words.delete();
        for (int i = 0; i < 32; i++) samp.push_back(8'($urandom));
        for (int i = 0; i < 8; i++)
            words.push_back(pack(samp[4*i], samp[4*i+1], samp[4*i+2], samp[4*i+3]));
        bp_en = 1;
        for (int i = 0; i < 8; i++) send(words[i], i == 7);
        drain();
        bp_en = 0;
        chk("rt_count", 32'(log0.size()), 32'd32);
        if (log0.size() == 32) begin
            for (int i = 0; i < 32; i++) chk("rt_byte", 32'(log0[i][31:24]), 32'(samp[i]));
            chk("rt_last", 32'(logl[31]), 32'h1);
        end

        clear_log();
        i_tvalid = 1'b1;
        i_tdata  = 32'h0A0B0C0D;
        i_tlast  = 1'b1;
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        i_tdata  = 32'h0;
        t = 0;
        while (log0.size() < 2 && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("mid_beats", 32'(log0.size()), 32'd2);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("mid_o_tvalid", 32'({o_tvalid0, o_tvalid1}), 32'h0);
        chk("mid_o_tlast",  32'({o_tlast0, o_tlast1}), 32'h0);
        @(posedge clk);
        #3 reset = 1'b0;
        @(negedge clk);
        chk("mid_i_tready", 32'({i_tready0, i_tready1}), 32'h3);
        nl = 0;
        for (int i = 0; i < logl.size(); i++) if (logl[i]) nl++;
        chk("mid_no_last", 32'(nl), 32'h0);
        @(posedge clk);
        #1;
        clear_log();
        send(32'h01020304, 1'b0);
        drain();
        chk("post_count", 32'(log0.size()), 32'd4);
        if (log0.size() > 0) chk("post_b0", log0[0], 32'h02000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
